// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes and address-decode helper.
package axi_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  // Number of low address bits that select a byte inside one data word.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite responder exposing NUM_REGS read/write registers with byte strobes.
// AW and W are accepted independently and latched; a write commits on the
// edge where both are available. Reads return the pre-write value when a
// read and a write of the same register share an edge.
module axi4lite_reg_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = addr_lsb(DATA_WIDTH);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Write-side state
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  axi_resp_t             r_bresp;
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Read-side state
  logic                  r_rvalid;
  axi_resp_t             r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Handshake and decode nets
  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [ADDR_WIDTH-1:0] w_wr_word;
  logic                  w_wr_in_range;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_word;
  logic                  w_rd_in_range;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_unused;

  // Protection attributes carry no meaning for this register bank.
  assign w_unused = ^{AWPROT, ARPROT, RESP_DECERR};

  // Ready flags are pure functions of local flops.
  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held && !r_bvalid;
  assign w_arready = !r_rvalid;

  assign w_aw_hs = AWVALID && w_awready;
  assign w_w_hs  = WVALID && w_wready;
  assign w_ar_hs = ARVALID && w_arready;

  // A channel counts as available when latched earlier or handshaking now.
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_waddr = r_aw_held ? r_awaddr : AWADDR;
  assign w_wdata = r_w_held ? r_wdata : WDATA;
  assign w_wstrb = r_w_held ? r_wstrb : WSTRB;

  // Word-index decode; byte-offset bits are dropped, so unaligned addresses truncate.
  assign w_wr_word     = w_waddr >> LSB;
  assign w_wr_in_range = (w_wr_word < ADDR_WIDTH'(NUM_REGS));
  assign w_wr_idx      = w_wr_word[IDX_W-1:0];

  assign w_rd_word     = ARADDR >> LSB;
  assign w_rd_in_range = (w_rd_word < ADDR_WIDTH'(NUM_REGS));
  assign w_rd_idx      = w_rd_word[IDX_W-1:0];

  // Write channel: latch AW/W, commit strobed bytes, raise and retire BVALID.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_wr_in_range) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (w_wstrb[k]) begin
              r_regs[w_wr_idx][k*8 +: 8] <= w_wdata[k*8 +: 8];
            end
          end
          r_wr_pulse[w_wr_idx] <= 1'b1;
          r_bresp              <= RESP_OKAY;
        end else begin
          r_bresp <= RESP_SLVERR;
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= WDATA;
          r_wstrb  <= WSTRB;
        end
        if (r_bvalid && BREADY) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  // Read channel: capture register (or zero/SLVERR) on AR, hold until RREADY.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        if (w_rd_in_range) begin
          r_rdata <= r_regs[w_rd_idx];
          r_rresp <= RESP_OKAY;
        end else begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      end else if (r_rvalid && RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Flatten the register array onto the fabric-facing bus.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign AWREADY  = w_awready;
  assign WREADY   = w_wready;
  assign ARREADY  = w_arready;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign RVALID   = r_rvalid;
  assign RRESP    = r_rresp;
  assign RDATA    = r_rdata;
  assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave: directed scenarios followed by
// randomized transactions compared against an array-based register model.
module tb_axi4lite_reg_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [AW-1:0]   AWADDR;
  logic [2:0]      AWPROT;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [AW-1:0]   ARADDR;
  logic [2:0]      ARPROT;
  logic            ARVALID;
  logic            ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]   wr_pulse;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_regs [NR];

  axi4lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [AW-1:0] addr);
    return (addr / 4) < NR;
  endfunction

  function automatic logic [NR-1:0] exp_pulse(input logic [AW-1:0] addr);
    logic [NR-1:0] one;
    one = {{(NR-1){1'b0}}, 1'b1};
    return in_range(addr) ? (one << (addr / 4)) : '0;
  endfunction

  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb);
    int idx;
    idx = int'(addr / 4);
    if (idx < NR) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) m_regs[idx][k*8 +: 8] = data[k*8 +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s_reg%0d", tag, i), reg_q[i*DW +: DW], m_regs[i]);
    end
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap idle cycles between.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int order, input int gap,
                          input int bdelay);
    logic [1:0] eresp;
    eresp = in_range(addr) ? 2'b00 : 2'b10;
    check("wr_awready_idle", AWREADY, 1);
    check("wr_wready_idle", WREADY, 1);
    BREADY = 1'b0;
    AWADDR = addr;
    WDATA  = data;
    WSTRB  = strb;
    AWPROT = 3'($urandom);
    if (order == 0) begin
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end else begin
      if (order == 1) AWVALID = 1'b1;
      else            WVALID  = 1'b1;
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      for (int g = 0; g <= gap; g++) begin
        check("wr_no_early_commit", BVALID, 0);
        if (order == 1) check("wr_awready_held", AWREADY, 0);
        else            check("wr_wready_held", WREADY, 0);
        if (g < gap) tick();
      end
      if (order == 1) WVALID  = 1'b1;
      else            AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end
    model_write(addr, data, strb);
    check("wr_bvalid", BVALID, 1);
    check("wr_bresp", BRESP, eresp);
    check("wr_pulse", wr_pulse, exp_pulse(addr));
    check("wr_awready_busy", AWREADY, 0);
    check("wr_wready_busy", WREADY, 0);
    check_regs("wr");
    for (int d = 0; d < bdelay; d++) begin
      tick();
      check("wr_bvalid_hold", BVALID, 1);
      check("wr_bresp_hold", BRESP, eresp);
      check("wr_pulse_once", wr_pulse, 0);
      check("wr_wready_hold", WREADY, 0);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("wr_bvalid_clear", BVALID, 0);
    check("wr_pulse_clear", wr_pulse, 0);
    check("wr_awready_back", AWREADY, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int rdelay);
    logic [DW-1:0] edata;
    logic [1:0]    eresp;
    edata = in_range(addr) ? m_regs[addr / 4] : '0;
    eresp = in_range(addr) ? 2'b00 : 2'b10;
    check("rd_arready_idle", ARREADY, 1);
    ARADDR  = addr;
    ARPROT  = 3'($urandom);
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    tick();
    ARVALID = 1'b0;
    check("rd_rvalid", RVALID, 1);
    check("rd_rdata", RDATA, edata);
    check("rd_rresp", RRESP, eresp);
    check("rd_arready_busy", ARREADY, 0);
    for (int d = 0; d < rdelay; d++) begin
      tick();
      check("rd_rvalid_hold", RVALID, 1);
      check("rd_rdata_hold", RDATA, edata);
      check("rd_rresp_hold", RRESP, eresp);
      check("rd_arready_hold", ARREADY, 0);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rd_rvalid_clear", RVALID, 0);
    check("rd_arready_back", ARREADY, 1);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    model_clear();
    repeat (2) @(posedge ACLK);
    #1;

    // Reset state
    check("rst_awready", AWREADY, 1);
    check("rst_wready", WREADY, 1);
    check("rst_arready", ARREADY, 1);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_reg_q_zero", (reg_q === '0), 1);
    ARESETn = 1'b1;
    tick();

    // Simultaneous AW/W write to register 2
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("t1_reg2", reg_q[2*DW +: DW], 32'hDEADBEEF);

    // W three cycles before AW, partial strobes, BREADY held off
    do_write(32'h08, 32'h11223344, 4'h5, 2, 2, 2);
    check("t2_reg2", reg_q[2*DW +: DW], 32'hDE22BE44);

    // Read with RREADY low for 5 cycles
    do_read(32'h08, 5);

    // Out-of-range write and read
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(32'h40, 0);

    // Same-edge write and read of register 3 returns the old value
    AWADDR = 32'h0C; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; ARADDR = 32'h0C;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("t5_rdata_old", RDATA, 32'h0);
    check("t5_rvalid", RVALID, 1);
    check("t5_bvalid", BVALID, 1);
    check("t5_reg3_new", reg_q[3*DW +: DW], 32'hA5A5A5A5);
    model_write(32'h0C, 32'hA5A5A5A5, 4'hF);
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    check("t5_bvalid_clear", BVALID, 0);
    check("t5_rvalid_clear", RVALID, 0);
    do_read(32'h0C, 0);
    check("t5_model_reg3", reg_q[3*DW +: DW], 32'hA5A5A5A5);

    // Reset with pending write and read responses
    AWADDR = 32'h04; WDATA = 32'h12345678; WSTRB = 4'hF; ARADDR = 32'h08;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("t6_bvalid_pending", BVALID, 1);
    check("t6_rvalid_pending", RVALID, 1);
    #2 ARESETn = 1'b0;
    #1;
    check("t6_bvalid_rst", BVALID, 0);
    check("t6_rvalid_rst", RVALID, 0);
    check("t6_rdata_rst", RDATA, 0);
    check("t6_reg_q_rst", (reg_q === '0), 1);
    check("t6_awready_rst", AWREADY, 1);
    model_clear();
    ARESETn = 1'b1;
    tick();

    // Reset with a latched AW discards it
    AWADDR = 32'h10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("t6_aw_held", AWREADY, 0);
    #2 ARESETn = 1'b0;
    #1;
    check("t6_aw_held_rst", AWREADY, 1);
    ARESETn = 1'b1;
    tick();
    WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("t6_w_alone_no_commit", BVALID, 0);
    check("t6_w_alone_held", WREADY, 0);
    AWADDR = 32'h10; AWVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("t6_late_aw_commit", BVALID, 1);
    check("t6_late_aw_pulse", wr_pulse, exp_pulse(32'h10));
    model_write(32'h10, 32'h0BADF00D, 4'hF);
    tick();
    BREADY = 1'b0;
    check("t6_late_aw_bclear", BVALID, 0);
    check_regs("t6");

    // Randomized transactions against the model
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 32'h4F));
      if ($urandom_range(0, 2) != 0) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        do_read(a, $urandom_range(0, 3));
      end
    end
    check_regs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time in case the DUT never responds.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
